// File: rtl/hlsm_job_sequencer.sv
// hlsm_job_sequencer: feeds operand triples to the scheduled HLSM one job at a time, with a timeout watchdog
module hlsm_job_sequencer #(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   output logic              hlsm_rst,
   output logic              hlsm_start,
   output logic [DATA_W-1:0] hlsm_a,
   output logic [DATA_W-1:0] hlsm_b,
   output logic [DATA_W-1:0] hlsm_c,
   input  logic              hlsm_done,
   input  logic [DATA_W-1:0] hlsm_z,
   input  logic [DATA_W-1:0] hlsm_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_z,
   output logic [DATA_W-1:0] out_x,
   output logic              out_timeout,
   output logic              busy,
   output logic [CNT_W-1:0]  job_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, OUT} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, z_q, z_d, x_q, x_d;
   logic to_q, to_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic in_ready_q, rst_q, start_q, valid_q, busy_q;

   // next-state: one job in flight, done beats the watchdog when both occur together
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      z_d     = z_q;
      x_d     = x_q;
      to_d    = to_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_valid && in_ready_q) begin
            a_d     = in_a;
            b_d     = in_b;
            c_d     = in_c;
            state_d = CLEAR;
         end
         CLEAR: state_d = LAUNCH;
         LAUNCH: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            if (hlsm_done) begin
               z_d     = hlsm_z;
               x_d     = hlsm_x;
               to_d    = 1'b0;
               state_d = OUT;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               z_d     = '0;
               x_d     = '0;
               to_d    = 1'b1;
               state_d = OUT;
            end
         end
         OUT: if (out_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state, datapath and output registers; strobes decode the upcoming state so they align with it
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         z_q        <= '0;
         x_q        <= '0;
         to_q       <= 1'b0;
         cnt_q      <= '0;
         in_ready_q <= 1'b1;
         rst_q      <= 1'b0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         z_q        <= z_d;
         x_q        <= x_d;
         to_q       <= to_d;
         cnt_q      <= cnt_d;
         in_ready_q <= state_d == IDLE;
         rst_q      <= state_d == CLEAR;
         start_q    <= state_d == LAUNCH;
         valid_q    <= state_d == OUT;
         busy_q     <= state_d != IDLE;
      end
   end

   assign in_ready    = in_ready_q;
   assign hlsm_rst    = rst_q;
   assign hlsm_start  = start_q;
   assign hlsm_a      = a_q;
   assign hlsm_b      = b_q;
   assign hlsm_c      = c_q;
   assign out_valid   = valid_q;
   assign out_z       = z_q;
   assign out_x       = x_q;
   assign out_timeout = to_q;
   assign busy        = busy_q;
   assign job_count   = cnt_q;
endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// tb_hlsm_job_sequencer: directed and random jobs against a stand-in HLSM and per-job expected results
module tb_hlsm_job_sequencer;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam int CW = 4;
   logic Clk = 1'b0, Rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
   logic in_ready, hlsm_rst, hlsm_start, out_valid, out_timeout, busy;
   logic [DW-1:0] hlsm_a, hlsm_b, hlsm_c, out_z, out_x;
   logic [CW-1:0] job_count;
   logic hlsm_done = 1'b0;
   logic [DW-1:0] hlsm_z = '0, hlsm_x = '0;
   int n_assert = 0, n_fail = 0, exp_cnt = 0, lat_cfg = 1, hl_cnt = 0;
   logic hl_run = 1'b0;

   hlsm_job_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .hlsm_rst(hlsm_rst), .hlsm_start(hlsm_start),
      .hlsm_a(hlsm_a), .hlsm_b(hlsm_b), .hlsm_c(hlsm_c),
      .hlsm_done(hlsm_done), .hlsm_z(hlsm_z), .hlsm_x(hlsm_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_x(out_x),
      .out_timeout(out_timeout), .busy(busy), .job_count(job_count)
   );

   always #5 Clk = ~Clk;

   // stand-in HLSM: done rises lat_cfg edges after start is seen, sticky until its reset; z/x not cleared by reset
   always @(posedge Clk) begin
      if (hlsm_rst) begin
         hlsm_done <= 1'b0;
         hl_run    <= 1'b0;
      end else if (hlsm_start) begin
         hl_run <= 1'b1;
         hl_cnt <= lat_cfg - 1;
      end else if (hl_run) begin
         if (hl_cnt == 0) begin
            hlsm_done <= 1'b1;
            hlsm_z    <= hlsm_a * hlsm_b + hlsm_c;
            hlsm_x    <= hlsm_a * hlsm_c - hlsm_a - hlsm_b;
            hl_run    <= 1'b0;
         end else hl_cnt <= hl_cnt - 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_job(input logic [DW-1:0] a, b, c, input int lat);
      lat_cfg = lat;
      check("idle_in_ready", in_ready, 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
      tick();
      in_valid = 1'b0;
      check("clear_pulse", {hlsm_rst, hlsm_start}, 2'b10);
      check("held_a", hlsm_a, a);
      check("held_bc", {hlsm_b, hlsm_c}, {b, c});
      check("busy_in_ready", {busy, in_ready}, 2'b10);
      tick();
      check("start_pulse", {hlsm_rst, hlsm_start}, 2'b01);
      check("done_cleared", hlsm_done, 0);
   endtask

   task automatic finish_job(input logic [DW-1:0] a, b, c, input int lat, input int bp);
      int k = 1;
      logic tmo = lat > TO - 1;
      logic [DW-1:0] ez = tmo ? '0 : a * b + c;
      logic [DW-1:0] ex = tmo ? '0 : a * c - a - b;
      do begin
         tick();
         k++;
      end while (!out_valid && k < 60);
      check("latency", k, tmo ? 2 + TO : 3 + lat);
      check("out_valid", out_valid, 1);
      check("out_zx", {out_z, out_x}, {ez, ex});
      check("out_timeout", out_timeout, tmo);
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         in_a = 32'hdead;
         tick();
         check("bp_hold", {out_valid, in_ready, out_timeout, out_z, out_x}, {2'b10, tmo, ez, ex});
         check("bp_no_accept", hlsm_a, a);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      check("handshake_done", {out_valid, busy, in_ready}, 3'b001);
      check("job_count", job_count, exp_cnt);
   endtask

   task automatic run_job(input logic [DW-1:0] a, b, c, input int lat, input int bp);
      start_job(a, b, c, lat);
      finish_job(a, b, c, lat, bp);
   endtask

   initial begin
      logic [DW-1:0] ra, rb, rc;
      repeat (3) tick();
      Rst = 1'b0;
      check("rst_ready", {in_ready, busy, out_valid, hlsm_rst, hlsm_start, out_timeout}, 6'b100000);
      check("rst_data", {hlsm_a, hlsm_b, hlsm_c, out_z, out_x}, '0);
      check("rst_count", job_count, 0);
      tick();
      run_job(5, 3, 2, 6, 0);
      run_job(10, 4, 3, 3, 10);
      run_job(7, 7, 7, 1000, 2);
      run_job(9, 2, 1, TO - 1, 0);
      check("stale_done_high", hlsm_done, 1);
      run_job(6, 5, 4, 5, 1);
      start_job(11, 12, 13, 1000);
      repeat (3) tick();
      #2 Rst = 1'b1;
      #1;
      check("async_rst", {busy, out_valid, in_ready, hlsm_rst, hlsm_start}, 5'b00100);
      check("async_rst_count", job_count, 0);
      exp_cnt = 0;
      #3 Rst = 1'b0;
      tick();
      for (int j = 0; j < 17; j++) begin
         ra = $urandom;
         rb = $urandom;
         rc = $urandom;
         run_job(ra, rb, rc, $urandom_range(1, TO + 1), $urandom_range(0, 3));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hlsm_job_sequencer.md
Name: hlsm_job_sequencer

Overview:
- Wraps the scheduled HLSM datapath, which has ports Clk/Rst/Start/Done, operands a/b/c and results z/x.
- Accepts operand triples on a valid/ready input stream and clears the HLSM before each job.
- Presents the operands, pulses Start, waits for Done with a timeout watchdog, then returns z/x on a valid/ready output stream.
- Sits directly upstream of the HLSM (feeds it) and captures its outputs.

Parameters:
DATA_W, 32, width of operands and results
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort (>=2)
CNT_W, 16, width of job counter

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset; asynchronous, active-high
in_valid  in  1  operand triple valid
in_ready  out  1  sequencer can accept a triple
in_a  in  DATA_W  operand a
in_b  in  DATA_W  operand b
in_c  in  DATA_W  operand c
hlsm_rst  out  1  registered clear pulse to HLSM Rst
hlsm_start  out  1  registered start pulse to HLSM Start
hlsm_a  out  DATA_W  held operand a to HLSM
hlsm_b  out  DATA_W  held operand b to HLSM
hlsm_c  out  DATA_W  held operand c to HLSM
hlsm_done  in  1  HLSM Done (level, sticky until HLSM reset)
hlsm_z  in  DATA_W  HLSM result z
hlsm_x  in  DATA_W  HLSM result x
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_z  out  DATA_W  captured z
out_x  out  DATA_W  captured x
out_timeout  out  1  qualifies out_*: job aborted by watchdog
busy  out  1  state != IDLE
job_count  out  CNT_W  completed output handshakes, wraps

Behaviour:
- Reset (async assert, sync to Clk on release):
  - State -> IDLE.
  - in_ready=1; all other outputs 0, including hlsm_a/b/c, out_z/x and job_count.
  - Timer = 0.
- FSM states: IDLE, CLEAR, LAUNCH, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/b/c into hlsm_a/b/c, then go to CLEAR.
- CLEAR (1 cycle): hlsm_rst=1; go to LAUNCH. This clears the sticky HLSM Done.
- LAUNCH (1 cycle): hlsm_start=1, timer=0; go to WAIT.
- WAIT:
  - hlsm_done is sampled each cycle and the timer increments.
  - If hlsm_done=1: capture hlsm_z/x into out_z/x, out_timeout=0, go to OUT.
  - Else if timer==TIMEOUT_CYCLES-1: out_z=out_x=0, out_timeout=1, go to OUT.
  - If done and the timeout coincide in the same cycle, done wins.
- OUT:
  - out_valid=1; out_z/x/out_timeout are held stable while out_valid && !out_ready.
  - On out_ready: job_count+1 (wraps at 2^CNT_W to 0), out_valid=0, go to IDLE.
- hlsm_done is ignored in IDLE, CLEAR, LAUNCH and OUT.
- hlsm_a/b/c stay constant from capture until the next accepted triple.
- in_ready=0 in every state except IDLE. No pipelining: one job in flight.
- Latency: input handshake at edge T produces:
  - hlsm_rst high during cycle T+1
  - hlsm_start high during T+2
  - first done sample at T+3
  - out_valid at D+1, where D is the edge at which done is sampled.
- Minimum issue interval: 5 cycles plus the HLSM compute time plus output backpressure.
- Rst asserted mid-job: immediate return to IDLE.
  - Any pending out_valid is dropped.
  - job_count is cleared.
  - hlsm_rst/hlsm_start are forced to 0.
- All outputs are registered.

Test Plan:
- Reset, then send a=5, b=3, c=2; the behavioural HLSM model asserts done 6 cycles after start.
  - Required: one hlsm_rst pulse, then one hlsm_start pulse.
  - Required: out_valid with out_z=17, out_x=2, out_timeout=0; job_count=1 after the handshake.
- Backpressure: hold out_ready=0 for 10 cycles with a=10, b=4, c=3.
  - Required: out_z=43, out_x=16 stable, in_ready=0 throughout.
  - Required: accepts the next triple only after the out_ready handshake.
- Timeout: TIMEOUT_CYCLES=8 and the model never asserts done.
  - Required: out_valid 8 cycles after entering WAIT, with out_timeout=1 and out_z=out_x=0.
- Coincidence: the model asserts done exactly on the final timer cycle.
  - Required: out_timeout=0 and valid z/x.
- Stale done: leave the HLSM Done high from the previous job, then start a new job.
  - Required: hlsm_rst clears Done, and the result is the new job's result, not the old one.
- Async Rst pulsed mid-WAIT between clock edges.
  - Required: busy=0, out_valid=0, job_count=0 immediately.
  - Required: a following job completes normally; CNT_W=4 wraps from 15 to 0 after 16 jobs.
